fff_round_controller: RTL and testbench
=======================================

# fff_round_controller

Round sequencer for the fastest-finger-first buzzer. It arms the player inputs after a quizmaster start, disqualifies players who press early, and captures exactly one winner (lowest index on a tie). It also enforces an answer window and holds the result until the quizmaster clears the round. It sits between the raw player buttons and the latch / priority-encoder / 7-segment path, and drives the latch enable and the winner code that the display shows.

## Interface
Parameters:
- ARM_DELAY, 16: number of clk cycles in COUNTDOWN before inputs go live; must be at least 1.
- WINDOW, 1000: number of clk cycles in ARMED before a no-winner timeout; must be at least 1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  quizmaster arm request; level-sampled; honoured only in IDLE.
- clear  in  1  quizmaster end-of-round; level-sampled; honoured in any state.
- btn_n  in  4  player buttons, active-low, asynchronous; bit 0 is P1.
- latch_en  out  1  high only in ARMED; drives the display latch enable.
- armed  out  1  high in ARMED.
- locked  out  1  high in LOCKED.
- timeout  out  1  high in TIMEOUT.
- winner  out  3  0 = none; 1..4 = player P1..P4; held while LOCKED.
- foul  out  4  sticky per-player early-press flags.
- buzz  out  1  one-cycle pulse on the cycle LOCKED is entered.

## Operation
- Input conditioning: each btn_n bit is inverted, then passed through a 2-flop synchronizer to produce the synchronized press vector p[3:0].
- The state machine has four states: IDLE, COUNTDOWN, ARMED and DONE. DONE has two variants, LOCKED and TIMEOUT.
- IDLE
  - Presses are ignored and do not count as fouls.
  - When start = 1 and clear = 0: go to COUNTDOWN, clear foul to 0, and load the counter with ARM_DELAY-1.
- COUNTDOWN
  - Any p[i] = 1 sets foul[i].
  - The counter decrements each cycle. When the counter is 0, go to ARMED and load the counter with WINDOW-1.
  - If all four foul bits are set when the count expires, go to TIMEOUT instead of ARMED.
- ARMED
  - The eligible press vector is q = p & ~foul.
  - If q is non-zero, go to LOCKED and set winner = 1 + the index of the lowest set bit of q (P1 has the highest priority). Pulse buzz.
  - Otherwise the counter decrements each cycle. When the counter is 0, go to TIMEOUT with winner = 0.
  - If an eligible press occurs in the same cycle as counter = 0, the press wins and the state goes to LOCKED.
- LOCKED / TIMEOUT: hold all outputs. start and further presses are ignored. Leave only on clear or rst.
- clear = 1 in any state: go to IDLE on the next edge, with winner = 0 and foul = 0. clear has priority over start, presses and counter expiry.
- rst has priority over everything.
- Reset values of all outputs:
  - latch_en = 0, armed = 0, locked = 0, timeout = 0, buzz = 0.
  - winner = 0, foul = 0.
  - State = IDLE, counter = 0, synchronizer flops = 0.
- Counter width is $clog2(max(ARM_DELAY, WINDOW)+1) bits, unsigned. It must never wrap, because loads happen only on state entry.
- A button held from IDLE into COUNTDOWN is fouled on its first synchronized cycle in COUNTDOWN.
- A button that is fouled and still held into ARMED is masked and can never win.

## Timing
- Press latency: let btn_n[i] first be sampled low at edge k. Then p[i] is high after edge k+1, and LOCKED, winner and buzz are visible after edge k+2. buzz falls after edge k+3.
- Simultaneous presses: if two or more bits of q become set on the same cycle, the lowest index wins.
- A press sampled low at edge k is counted in a given state only if p[i] is high during that state.
- start sampled at edge e:
  - COUNTDOWN is visible after edge e.
  - ARMED is visible after edge e+ARM_DELAY.
  - latch_en rises in that same cycle.
- With no press, TIMEOUT is visible after edge e+ARM_DELAY+WINDOW.
- clear sampled at edge c: IDLE is visible after edge c, and every output is back at its reset value except the synchronizer contents.
- start held high continuously: it is accepted once from IDLE only. After a clear it is re-accepted on the next edge if start is still high.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Use ARM_DELAY=4 and WINDOW=8 for all scenarios.
- Reset: assert rst for 2 cycles mid-ARMED -> all outputs 0 and state IDLE on the next cycle; a subsequent start leads to ARMED 4 cycles later.
- Single winner: start, then press P3 (btn_n=4'b1011) 2 cycles into ARMED -> winner=3, locked=1, buzz high for exactly 1 cycle, latch_en=0. Later presses by P1 leave winner=3.
- Tie: P2 and P4 are pressed in the same cycle during ARMED -> winner=2.
- Foul: P1 is pressed during COUNTDOWN and held through ARMED, then P4 presses -> foul=4'b0001 and winner=4. With all four players fouled -> TIMEOUT right after COUNTDOWN, winner=0.
- Timeout boundary: no press -> timeout=1 exactly 12 cycles after start is sampled. A press whose p[i] rises in the last ARMED cycle -> LOCKED, not TIMEOUT.
- Clear priority: clear and start asserted together in IDLE -> stays IDLE. clear asserted in the same cycle as an eligible press in ARMED -> IDLE, winner=0, no buzz.

Source files
------------

// File: rtl/fff_round_controller.sv
// Fastest-finger-first round sequencer: arms the player buttons after a start,
// flags early presses as fouls, captures one winner and enforces the answer window.
module fff_round_controller #(
  parameter int ARM_DELAY = 16,
  parameter int WINDOW    = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       clear,
  input  logic [3:0] btn_n,
  output logic       latch_en,
  output logic       armed,
  output logic       locked,
  output logic       timeout,
  output logic [2:0] winner,
  output logic [3:0] foul,
  output logic       buzz
);

  localparam int MAX_CNT = (ARM_DELAY > WINDOW) ? ARM_DELAY : WINDOW;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] ARM_LOAD = CNT_W'(ARM_DELAY - 1);
  localparam logic [CNT_W-1:0] WIN_LOAD = CNT_W'(WINDOW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNTDOWN,
    S_ARMED,
    S_LOCKED,
    S_TIMEOUT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       winner_q, winner_d;
  logic [3:0]       foul_q, foul_d;
  logic             buzz_q, buzz_d;
  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       eligible;

  // Lowest index wins a tie; 0 means nobody pressed.
  function automatic logic [2:0] first_press(input logic [3:0] q);
    if (q[0])      return 3'd1;
    else if (q[1]) return 3'd2;
    else if (q[2]) return 3'd3;
    else if (q[3]) return 3'd4;
    else           return 3'd0;
  endfunction

  assign eligible = sync2_q & ~foul_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    winner_d = winner_q;
    foul_d   = foul_q;
    buzz_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_COUNTDOWN;
          foul_d  = 4'b0000;
          cnt_d   = ARM_LOAD;
        end
      end
      S_COUNTDOWN: begin
        foul_d = foul_q | sync2_q;
        if (cnt_q == '0) begin
          if (&foul_d) begin
            state_d  = S_TIMEOUT;
            winner_d = 3'd0;
          end else begin
            state_d = S_ARMED;
            cnt_d   = WIN_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ARMED: begin
        // An eligible press beats window expiry in the same cycle.
        if (|eligible) begin
          state_d  = S_LOCKED;
          winner_d = first_press(eligible);
          buzz_d   = 1'b1;
        end else if (cnt_q == '0) begin
          state_d  = S_TIMEOUT;
          winner_d = 3'd0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
    if (clear) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      winner_d = 3'd0;
      foul_d   = 4'b0000;
      buzz_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      winner_q <= 3'd0;
      foul_q   <= 4'b0000;
      buzz_q   <= 1'b0;
      sync1_q  <= 4'b0000;
      sync2_q  <= 4'b0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      winner_q <= winner_d;
      foul_q   <= foul_d;
      buzz_q   <= buzz_d;
      sync1_q  <= ~btn_n;
      sync2_q  <= sync1_q;
    end
  end

  assign latch_en = (state_q == S_ARMED);
  assign armed    = (state_q == S_ARMED);
  assign locked   = (state_q == S_LOCKED);
  assign timeout  = (state_q == S_TIMEOUT);
  assign winner   = winner_q;
  assign foul     = foul_q;
  assign buzz     = buzz_q;

endmodule

// File: tb/tb_fff_round_controller.sv
// Directed bench for fff_round_controller with ARM_DELAY=4, WINDOW=8; expected
// output snapshots are queued when a step is driven and compared after the edge.
module tb_fff_round_controller;

  logic       clk = 1'b0;
  logic       rst, start, clear;
  logic [3:0] btn_n;
  logic       latch_en, armed, locked, timeout, buzz;
  logic [2:0] winner;
  logic [3:0] foul;

  int errors = 0;
  int checks = 0;

  logic [11:0] exp_q[$];
  string       tag_q[$];

  localparam logic [3:0] S_IDL = 4'b0000;
  localparam logic [3:0] S_ARM = 4'b1100;
  localparam logic [3:0] S_LCK = 4'b0010;
  localparam logic [3:0] S_TMO = 4'b0001;

  fff_round_controller #(.ARM_DELAY(4), .WINDOW(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .clear   (clear),
    .btn_n   (btn_n),
    .latch_en(latch_en),
    .armed   (armed),
    .locked  (locked),
    .timeout (timeout),
    .winner  (winner),
    .foul    (foul),
    .buzz    (buzz)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ex(input logic [3:0] st, input logic bz,
                                     input logic [2:0] w, input logic [3:0] f);
    return {st, bz, w, f};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Queue the expected snapshot, advance one edge, then pop and compare.
  task automatic step_expect(input string tag, input logic [11:0] e);
    logic [11:0] obs;
    logic [11:0] want;
    string       t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    cyc();
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      t    = tag_q.pop_front();
      obs  = {latch_en, armed, locked, timeout, buzz, winner, foul};
      checks++;
      assert (obs === want) else begin
        errors++;
        $error("FAIL %s: observed le/arm/lck/tmo/buzz/win/foul=%b_%b_%0d_%b expected %b_%b_%0d_%b",
               t, obs[11:8], obs[7], obs[6:4], obs[3:0],
               want[11:8], want[7], want[6:4], want[3:0]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; btn_n = 4'hF;
    cyc();
    step_expect("reset", ex(S_IDL, 0, 0, 4'h0));
    rst = 1'b0;

    // Countdown length, then reset in the middle of ARMED
    start = 1'b1;
    step_expect("cd_entry", ex(S_IDL, 0, 0, 4'h0));
    start = 1'b0;
    cyc(); cyc();
    step_expect("cd_e3", ex(S_IDL, 0, 0, 4'h0));
    step_expect("armed_e4", ex(S_ARM, 0, 0, 4'h0));
    rst = 1'b1;
    step_expect("rst_mid_armed_1", ex(S_IDL, 0, 0, 4'h0));
    step_expect("rst_mid_armed_2", ex(S_IDL, 0, 0, 4'h0));
    rst = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc();
    step_expect("rearm_e3", ex(S_IDL, 0, 0, 4'h0));
    step_expect("rearm_e4", ex(S_ARM, 0, 0, 4'h0));

    // Single winner P3, late P1 press ignored
    cyc();
    btn_n = 4'b1011;
    step_expect("p3_k", ex(S_ARM, 0, 0, 4'h0));
    step_expect("p3_k1", ex(S_ARM, 0, 0, 4'h0));
    step_expect("p3_lock", ex(S_LCK, 1, 3, 4'h0));
    step_expect("p3_buzz_fall", ex(S_LCK, 0, 3, 4'h0));
    btn_n = 4'b1110;
    cyc(); cyc();
    step_expect("p1_late", ex(S_LCK, 0, 3, 4'h0));
    btn_n = 4'hF; clear = 1'b1;
    step_expect("clear_locked", ex(S_IDL, 0, 0, 4'h0));
    clear = 1'b0; cyc(); cyc();

    // Tie between P2 and P4
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc(); cyc();
    step_expect("tie_armed", ex(S_ARM, 0, 0, 4'h0));
    btn_n = 4'b0101;
    cyc(); cyc();
    step_expect("tie_lock", ex(S_LCK, 1, 2, 4'h0));
    btn_n = 4'hF; clear = 1'b1; cyc(); clear = 1'b0; cyc(); cyc();

    // P1 fouls in countdown and stays masked; P4 wins
    start = 1'b1; cyc(); start = 1'b0;
    btn_n = 4'b1110;
    cyc(); cyc();
    step_expect("foul_cd", ex(S_IDL, 0, 0, 4'b0001));
    step_expect("foul_armed", ex(S_ARM, 0, 0, 4'b0001));
    cyc();
    step_expect("foul_masked", ex(S_ARM, 0, 0, 4'b0001));
    btn_n = 4'b0110;
    cyc(); cyc();
    step_expect("foul_p4_win", ex(S_LCK, 1, 4, 4'b0001));
    btn_n = 4'hF; clear = 1'b1;
    step_expect("foul_clear", ex(S_IDL, 0, 0, 4'h0));
    clear = 1'b0; cyc(); cyc();

    // Everybody fouls: straight to TIMEOUT
    start = 1'b1; cyc(); start = 1'b0;
    btn_n = 4'b0000;
    cyc(); cyc();
    step_expect("foul_all_cd", ex(S_IDL, 0, 0, 4'hF));
    step_expect("foul_all_tmo", ex(S_TMO, 0, 0, 4'hF));
    btn_n = 4'hF; clear = 1'b1; cyc(); clear = 1'b0; cyc(); cyc();

    // Window expiry with no press
    start = 1'b1; cyc(); start = 1'b0;
    repeat (10) cyc();
    step_expect("tmo_e11", ex(S_ARM, 0, 0, 4'h0));
    step_expect("tmo_e12", ex(S_TMO, 0, 0, 4'h0));
    cyc();
    step_expect("tmo_hold", ex(S_TMO, 0, 0, 4'h0));
    clear = 1'b1; cyc(); clear = 1'b0; cyc();

    // Press reaching p in the last ARMED cycle still wins
    start = 1'b1; cyc(); start = 1'b0;
    repeat (9) cyc();
    btn_n = 4'b1101;
    cyc();
    step_expect("last_e11", ex(S_ARM, 0, 0, 4'h0));
    step_expect("last_lock", ex(S_LCK, 1, 2, 4'h0));
    btn_n = 4'hF; clear = 1'b1; cyc(); clear = 1'b0; cyc(); cyc();

    // clear beats start; start re-accepted once clear drops
    clear = 1'b1; start = 1'b1;
    step_expect("clr_start", ex(S_IDL, 0, 0, 4'h0));
    cyc();
    clear = 1'b0;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    step_expect("clr_start_e3", ex(S_IDL, 0, 0, 4'h0));
    step_expect("clr_start_e4", ex(S_ARM, 0, 0, 4'h0));

    // clear coincides with an eligible press
    btn_n = 4'b1110;
    cyc(); cyc();
    clear = 1'b1;
    step_expect("clr_press", ex(S_IDL, 0, 0, 4'h0));
    clear = 1'b0; btn_n = 4'hF;
    step_expect("clr_press_after", ex(S_IDL, 0, 0, 4'h0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
